// File: rtl/lut6_cfg_pkg.sv
// rtl/lut6_cfg_pkg.sv - shared types and helpers for the LUT6 configuration controller
package lut6_cfg_pkg;

  localparam int LUT_BITS = 64;
  localparam int SEL_W    = 6;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  function automatic bit chunk_ok(input int chunk_w);
    return (chunk_w > 0) && (chunk_w <= LUT_BITS) && ((LUT_BITS % chunk_w) == 0);
  endfunction

  function automatic int nbeats(input int chunk_w);
    return LUT_BITS / chunk_w;
  endfunction

  function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
    return d[s];
  endfunction

endpackage

// File: rtl/lut6_mux.sv
// rtl/lut6_mux.sv - combinational 64:1 truth-table select as a three-level 4:1 tree
module lut6_mux
  import lut6_cfg_pkg::*;
(
  input  logic [LUT_BITS-1:0] i_table,
  input  logic [SEL_W-1:0]    i_sel,
  output logic                o_z
);

  logic [15:0] w_lvl1;
  logic [3:0]  w_lvl2;

  for (genvar g = 0; g < 16; g++) begin : g_lvl1
    assign w_lvl1[g] = mux4(i_table[g*4 +: 4], i_sel[1:0]);
  end

  for (genvar g = 0; g < 4; g++) begin : g_lvl2
    assign w_lvl2[g] = mux4(w_lvl1[g*4 +: 4], i_sel[3:2]);
  end

  assign o_z = mux4(w_lvl2, i_sel[5:4]);

endmodule

// File: rtl/lut6_cfg_ctrl.sv
// rtl/lut6_cfg_ctrl.sv - reconfigurable LUT6: chunked shadow load, atomic commit, continuous lookup
module lut6_cfg_ctrl
  import lut6_cfg_pkg::*;
#(
  parameter int          CHUNK_W      = 4,
  parameter logic [63:0] INIT_DEFAULT = 64'h0,
  parameter bit          REG_OUT      = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CHUNK_W-1:0] i_cfg_data,
  input  logic               i_cfg_last,
  output logic               o_cfg_done,
  output logic               o_cfg_err,
  input  logic [SEL_W-1:0]   i_sel,
  output logic               o_z,
  output logic [LUT_BITS-1:0] o_active_init
);

  if (!chunk_ok(CHUNK_W)) begin : g_bad_chunk
    $error("lut6_cfg_ctrl: CHUNK_W must divide 64");
  end

  localparam int               NBEATS   = nbeats(CHUNK_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  cfg_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [LUT_BITS-1:0] r_shadow;
  logic [LUT_BITS-1:0] r_active;
  logic                r_ready;
  logic                r_done;
  logic                r_err;

  logic       w_accept;
  logic       w_final_beat;
  logic [5:0] w_wr_base;
  logic       w_mux_z;

  assign w_accept     = i_cfg_valid & r_ready;
  assign w_final_beat = (r_cnt == LAST_CNT);
  assign w_wr_base    = 6'(int'(r_cnt) * CHUNK_W);

  // Framing is judged per beat: only the final beat may (and must) carry LAST.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= INIT_DEFAULT;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            r_shadow[w_wr_base +: CHUNK_W] <= i_cfg_data;
            if (w_final_beat && i_cfg_last) begin
              r_state <= COMMIT;
              r_ready <= 1'b0;
            end else if (w_final_beat || i_cfg_last) begin
              r_err   <= 1'b1;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= LOAD;
            end
          end
        end
        COMMIT: begin
          r_active <= r_shadow;
          r_cnt    <= '0;
          r_done   <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  lut6_mux u_mux (
    .i_table (r_active),
    .i_sel   (i_sel),
    .o_z     (w_mux_z)
  );

  // The output flop samples the pre-commit table in the COMMIT cycle, so no mixed value appears.
  if (REG_OUT) begin : g_reg_out
    logic r_z;
    always_ff @(posedge i_clk) begin
      if (i_rst) r_z <= 1'b0;
      else       r_z <= w_mux_z;
    end
    assign o_z = r_z;
  end else begin : g_comb_out
    assign o_z = w_mux_z;
  end

  assign o_cfg_ready   = r_ready;
  assign o_cfg_done    = r_done;
  assign o_cfg_err     = r_err;
  assign o_active_init = r_active;

endmodule

// File: tb/tb_lut6_cfg_ctrl.sv
// tb/tb_lut6_cfg_ctrl.sv - scoreboard bench for lut6_cfg_ctrl, registered and combinational lookup
module tb_lut6_cfg_ctrl;

  localparam int          CW     = 4;
  localparam int          NB     = 64 / CW;
  localparam logic [63:0] INIT   = 64'h0;
  localparam int          K_DONE = 1;
  localparam int          K_ERR  = 2;

  typedef struct {
    int          kind;
    longint      due;
    logic [63:0] tbl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_last = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic [5:0]    sel = '0;

  logic        ready1, done1, err1, z1;
  logic [63:0] act1;
  logic        ready0, done0, err0, z0;
  logic [63:0] act0;

  int          n_vec = 0;
  int          n_miss = 0;
  longint      cyc = 0;
  exp_t        q[$];
  logic [63:0] cur_exp = INIT;
  logic        pipe_z = 1'b0;
  int          sel_mode = 0;
  logic [5:0]  sel_hold = '0;

  lut6_cfg_ctrl #(.CHUNK_W(CW), .INIT_DEFAULT(INIT), .REG_OUT(1'b1)) dut_reg (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(ready1),
    .i_cfg_data(cfg_data), .i_cfg_last(cfg_last), .o_cfg_done(done1), .o_cfg_err(err1),
    .i_sel(sel), .o_z(z1), .o_active_init(act1)
  );

  lut6_cfg_ctrl #(.CHUNK_W(CW), .INIT_DEFAULT(INIT), .REG_OUT(1'b0)) dut_comb (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(ready0),
    .i_cfg_data(cfg_data), .i_cfg_last(cfg_last), .o_cfg_done(done0), .o_cfg_err(err0),
    .i_sel(sel), .o_z(z0), .o_active_init(act0)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Lookup index: 0 random, 1 sweep, 2 held at sel_hold.
  initial forever begin
    @(posedge clk);
    #1;
    if (sel_mode == 0)      sel = 6'($urandom);
    else if (sel_mode == 1) sel = sel + 6'd1;
    else                    sel = sel_hold;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        pipe_z  = 1'b0;
        cur_exp = INIT;
        q.delete();
      end else begin
        chk("z_registered", z1, pipe_z);
        if (done1 || err1 || (q.size() != 0 && q[0].due <= cyc)) begin
          if (q.size() == 0) begin
            chk("unexpected_pulse", {done1, err1}, 2'b00);
          end else begin
            e = q.pop_front();
            chk("pulse_cycle", cyc, e.due);
            chk("done_reg", done1, e.kind == K_DONE);
            chk("err_reg", err1, e.kind == K_ERR);
            chk("done_comb", done0, e.kind == K_DONE);
            chk("err_comb", err0, e.kind == K_ERR);
            if (e.kind == K_DONE) cur_exp = e.tbl;
          end
        end else begin
          chk("quiet_comb", {done0, err0}, 2'b00);
        end
        exp_rdy = !(q.size() != 0 && q[0].kind == K_DONE && q[0].due == cyc + 1);
        chk("ready_reg", ready1, exp_rdy);
        chk("ready_comb", ready0, exp_rdy);
        chk("active_reg", act1, cur_exp);
        chk("active_comb", act0, cur_exp);
        chk("z_comb", z0, cur_exp[sel]);
        pipe_z = cur_exp[sel];
      end
    end
  end

  task automatic send_beat(input logic [CW-1:0] d, input logic l, output bit ok, output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    while (!acc && waited < 20) begin
      @(negedge clk);
      acc = ready1;
      step();
      waited++;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    ok = acc;
    if (!acc) chk("beat_accept_timeout", 1'b0, 1'b1);
  endtask

  // last_at: beat carrying LAST (-1 none); stop_after: abandon before this beat index.
  task automatic send_frame(input logic [63:0] tbl, input int last_at, input int stop_after,
                            input int gap_max, output int first_wait);
    bit   ok;
    int   w;
    exp_t e;
    first_wait = 0;
    for (int k = 0; k < NB; k++) begin
      if (k == stop_after) return;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) step();
      send_beat(tbl[k*CW +: CW], k == last_at, ok, w);
      if (k == 0) first_wait = w;
      if (!ok) return;
      if (k == last_at || k == NB - 1) begin
        e.tbl = tbl;
        if (k == NB - 1 && k == last_at) begin
          e.kind = K_DONE;
          e.due  = cyc + 1;
        end else begin
          e.kind = K_ERR;
          e.due  = cyc;
        end
        q.push_back(e);
        return;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          w;
    int          r;
    int          last_at;
    int          sv[3];
    logic        ev[3];
    sv = '{4, 5, 63};
    ev = '{1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready1, 1'b1);
    chk("rst_done", done1, 1'b0);
    chk("rst_err", err1, 1'b0);
    chk("rst_z", z1, 1'b0);
    chk("rst_active", act1, INIT);
    step();

    sel_mode = 0;
    send_frame(64'hFEDC_BA98_7654_3210, NB - 1, 99, 0, w);
    repeat (3) step();
    chk("load1_active", act1, 64'hFEDC_BA98_7654_3210);
    sel_mode = 2;
    for (int i = 0; i < 3; i++) begin
      sel_hold = sv[i][5:0];
      step();
      step();
      @(negedge clk);
      chk("z_directed", z1, ev[i]);
      step();
    end

    sel_mode = 0;
    send_frame({$urandom, $urandom}, 3, 99, 0, w);
    repeat (2) step();
    chk("after_early_last", act1, 64'hFEDC_BA98_7654_3210);
    send_frame({$urandom, $urandom}, NB - 1, 99, 1, w);
    repeat (3) step();

    send_frame({$urandom, $urandom}, -1, 99, 0, w);
    repeat (3) step();

    sel_mode = 1;
    send_frame({$urandom, $urandom}, -1, 9, 0, w);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midload_rst_active", act1, INIT);
    chk("midload_rst_ready", ready1, 1'b1);
    chk("midload_rst_pulses", {done1, err1}, 2'b00);
    step();
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, NB - 1, 99, 0, w);
    repeat (70) step();

    send_frame({$urandom, $urandom}, NB - 1, 99, 0, w);
    send_frame({$urandom, $urandom}, NB - 1, 99, 0, w);
    chk("commit_stall_wait", w, 2);
    repeat (3) step();

    send_frame({$urandom, $urandom}, NB - 1, 99, 2, w);
    repeat (3) step();

    for (int n = 0; n < 40; n++) begin
      sel_mode = int'($urandom_range(1, 0));
      r = int'($urandom_range(9, 0));
      if (r < 7)       last_at = NB - 1;
      else if (r == 7) last_at = -1;
      else             last_at = int'($urandom_range(NB - 2, 0));
      send_frame({$urandom, $urandom}, last_at, 99, int'($urandom_range(2, 0)), w);
      repeat ($urandom_range(3, 0)) step();
    end

    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
